// File: rtl/sign_narrower_32to5.sv
`default_nettype none
// ============================================================================
// Module   : sign_narrower_32to5
// Brief    : Two-stage valid/ready narrowing of signed words to a short signed
//            field, with overflow flag and a saturating overflow counter.
// Revision : 1.0 - initial release
// ============================================================================
module sign_narrower_32to5 #(
    parameter int IN_W     = 32,
    parameter int OUT_W    = 5,
    parameter int SATURATE = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    input  logic             clr_count,
    output logic [CNT_W-1:0] ovf_count
);

    localparam int               c_hi_w    = IN_W - OUT_W + 1;
    localparam logic [OUT_W-1:0] c_sat_max = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] c_sat_min = {1'b1, {(OUT_W-1){1'b0}}};

    logic             r_s1_valid;
    logic [IN_W-1:0]  r_s1_word;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_ovf;
    logic [CNT_W-1:0] r_ovf_count;

    logic             w_accept;
    logic             w_s2_load;
    logic             w_ovf_xfer;
    logic [c_hi_w-1:0] w_hi;
    logic             w_fit;
    logic [OUT_W-1:0] w_narrow;

    // S2 frees up in the same cycle it is drained, so S1 can always move on.
    assign w_s2_load  = r_s1_valid & (~r_out_valid | out_ready);
    assign in_ready   = ~r_s1_valid | ~r_out_valid | out_ready;
    assign w_accept   = in_valid & in_ready;
    assign w_ovf_xfer = r_out_valid & out_ready & r_out_ovf;

    // The value fits when every bit from the MSB down to the narrow sign bit agrees.
    assign w_hi  = r_s1_word[IN_W-1:OUT_W-1];
    assign w_fit = (&w_hi) | ~(|w_hi);

    generate
        if (SATURATE != 0) begin : g_sat
            assign w_narrow = w_fit ? r_s1_word[OUT_W-1:0]
                                    : (r_s1_word[IN_W-1] ? c_sat_min : c_sat_max);
        end else begin : g_trunc
            assign w_narrow = r_s1_word[OUT_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_word   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1_word <= in_data;
            end

            if (w_accept) begin
                r_s1_valid <= 1'b1;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end

            if (w_s2_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_narrow;
                r_out_ovf   <= ~w_fit;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Clear takes priority over a coincident overflowed transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf_count <= '0;
        end else if (clr_count) begin
            r_ovf_count <= '0;
        end else if (w_ovf_xfer && !(&r_ovf_count)) begin
            r_ovf_count <= r_ovf_count + 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;
    assign ovf_count = r_ovf_count;

endmodule
`default_nettype wire

// File: tb/tb_sign_narrower_32to5.sv
`default_nettype none
// ============================================================================
// Module   : tb_sign_narrower_32to5
// Brief    : Scoreboard bench driving three narrower builds (truncate, saturate,
//            2-bit counter) from one stimulus stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sign_narrower_32to5;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        clr_count;

    logic        in_ready0, in_ready1, in_ready2;
    logic        out_valid0, out_valid1, out_valid2;
    logic [4:0]  out_data0, out_data1, out_data2;
    logic        out_ovf0, out_ovf1, out_ovf2;
    logic [15:0] cnt0, cnt1;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];
    int          c0 = 0, c1 = 0, c2 = 0;
    int          rdy_mode = 0;
    int          pi = 0;
    bit          pat[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    sign_narrower_32to5 #(.IN_W(32), .OUT_W(5), .SATURATE(0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_data(out_data0), .out_ovf(out_ovf0), .clr_count(clr_count), .ovf_count(cnt0));

    sign_narrower_32to5 #(.IN_W(32), .OUT_W(5), .SATURATE(1), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
        .out_data(out_data1), .out_ovf(out_ovf1), .clr_count(clr_count), .ovf_count(cnt1));

    sign_narrower_32to5 #(.IN_W(32), .OUT_W(5), .SATURATE(0), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .out_ovf(out_ovf2), .clr_count(clr_count), .ovf_count(cnt2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain signed arithmetic on the input value.
    function automatic bit fits(input logic [31:0] x);
        int v;
        v = $signed(x);
        return (v >= -16) && (v <= 15);
    endfunction

    function automatic logic [4:0] narrow(input logic [31:0] x, input bit sat);
        int v;
        int m;
        v = $signed(x);
        if (sat && v > 15)       m = 15;
        else if (sat && v < -16) m = -16;
        else                     m = v;
        m = ((m % 32) + 32) % 32;
        return m[4:0];
    endfunction

    function automatic int inc_sat(input int c, input int max);
        return (c >= max) ? max : c + 1;
    endfunction

    // Input side: record every accepted word and check ready against occupancy.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
        end else begin
            chk("in_ready0", {31'd0, in_ready0}, {31'd0, (q.size() < 2) || out_ready});
            chk("in_ready1", {31'd0, in_ready1}, {31'd0, (q.size() < 2) || out_ready});
            chk("in_ready2", {31'd0, in_ready2}, {31'd0, (q.size() < 2) || out_ready});
            if (in_valid && in_ready0) q.push_back(in_data);
        end
    end

    // Output monitor: compare the head item whenever an output is presented.
    always @(negedge clk) begin
        logic [31:0] x;
        bit          xfer;
        bit          ov;
        #2;
        if (reset) begin
            c0 = 0; c1 = 0; c2 = 0;
        end else begin
            chk("ovf_count0", {16'd0, cnt0}, c0);
            chk("ovf_count1", {16'd0, cnt1}, c1);
            chk("ovf_count2", {30'd0, cnt2}, c2);
            xfer = out_valid0 && out_ready;
            ov   = 1'b0;
            if (out_valid0 || out_valid1 || out_valid2) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", {29'd0, out_valid0, out_valid1, out_valid2}, 32'd0);
                end else begin
                    x  = q[0];
                    ov = !fits(x);
                    chk("out_valid1", {31'd0, out_valid1}, 32'd1);
                    chk("out_valid2", {31'd0, out_valid2}, 32'd1);
                    chk("out_data_trunc", {27'd0, out_data0}, {27'd0, narrow(x, 1'b0)});
                    chk("out_data_sat",   {27'd0, out_data1}, {27'd0, narrow(x, 1'b1)});
                    chk("out_data_c2",    {27'd0, out_data2}, {27'd0, narrow(x, 1'b0)});
                    chk("out_ovf0", {31'd0, out_ovf0}, {31'd0, ov});
                    chk("out_ovf1", {31'd0, out_ovf1}, {31'd0, ov});
                    if (!ov) chk("sign_extend", {{27{out_data0[4]}}, out_data0}, x);
                    if (xfer) void'(q.pop_front());
                end
            end
            if (clr_count) begin
                c0 = 0; c1 = 0; c2 = 0;
            end else if (xfer && ov) begin
                c0 = inc_sat(c0, 65535);
                c1 = inc_sat(c1, 65535);
                c2 = inc_sat(c2, 3);
            end
        end
    end

    // Background out_ready driver: 1 = fixed pattern, 2 = random; 0 leaves it alone.
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 1) begin
            out_ready = pat[pi];
            pi = (pi + 1) % 8;
        end else if (rdy_mode == 2) begin
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [31:0] x);
        bit acc;
        int n;
        in_valid = 1'b1;
        in_data  = x;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready0;
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 200);
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        bit done;
        in_valid  = 1'b0;
        rdy_mode  = 0;
        out_ready = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !out_valid0) done = 1'b1;
        end
        chk("drain_done", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_count = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid0}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready0},  32'd1);
        chk("rst_out_data",  {27'd0, out_data0},  32'd0);
        chk("rst_out_ovf",   {31'd0, out_ovf0},   32'd0);
        chk("rst_ovf_count", {16'd0, cnt0},       32'd0);
        @(posedge clk);
        #1;

        // Item offered after edge N is taken at N+1 and visible after N+2.
        out_ready = 1'b1;
        send(32'h0000_0002);
        in_valid = 1'b0;
        @(negedge clk);
        chk("latency_early", {31'd0, out_valid0}, 32'd0);
        @(negedge clk);
        chk("latency_on_time", {31'd0, out_valid0}, 32'd1);
        @(posedge clk);
        #1;
        drain();

        rdy_mode = 2;
        for (int v = -16; v <= 15; v++) send(32'(v));
        drain();

        clr_count = 1'b1;
        @(posedge clk);
        #1 clr_count = 1'b0;
        send(32'h0000_0010);
        send(32'hFFFF_FFEF);
        send(32'h8000_0000);
        drain();
        chk("ovf_count_three", {16'd0, cnt0}, 32'd3);
        send(32'h7FFF_FFFF);
        send(32'h8000_0000);
        send(32'hFFFF_FFFF);
        drain();
        chk("ovf_count_five", {16'd0, cnt0}, 32'd5);
        chk("ovf_count_sticky", {30'd0, cnt2}, 32'd3);

        out_ready = 1'b0;
        send(32'h1234_5678);
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid0;
        end
        chk("sixth_ovf_ready", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1; clr_count = 1'b1;
        @(posedge clk);
        #1 clr_count = 1'b0;
        @(negedge clk);
        chk("clr_wins_c2", {30'd0, cnt2}, 32'd0);
        chk("clr_wins_c0", {16'd0, cnt0}, 32'd0);
        @(posedge clk);
        #1;

        pi = 0;
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) send($urandom_range(0, 63) - 32'd32);
        drain();

        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 3))
                0:       send($urandom);
                1:       send($urandom_range(0, 40) - 32'd20);
                2:       send({{16{1'b1}}, 16'($urandom)});
                default: begin
                    in_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            endcase
        end
        drain();

        // Fill both stages, then reset while stalled.
        out_ready = 1'b0;
        send(32'h0000_0040);
        send(32'hFFFF_FF00);
        in_data = 32'h5;
        @(negedge clk);
        chk("full_in_ready", {31'd0, in_ready0}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid0}, 32'd0);
        chk("midrst_ovf_count", {16'd0, cnt0},       32'd0);
        chk("midrst_in_ready",  {31'd0, in_ready0},  32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_stale_item", {31'd0, out_valid0}, 32'd0);
        end
        @(posedge clk);
        #1;
        send(32'hFFFF_FFF0);
        send(32'h0000_000F);
        drain();

        chk("queue_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
